md_arbiter: RTL and testbench
=============================

MD_ARBITER -- requirements
Module: md_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), reset input 1 (synchronous, active-high).
REQ-002 For requester n = 0, 1, the block SHALL provide:
- reqn_valid  input  1  request pending.
- reqn_op  input  4  MD opcode.
- reqn_rs  input  32  operand A.
- reqn_rt  input  32  operand B.
- reqn_ready  output  1  request accepted this cycle.
- respn_valid  output  1  one-cycle completion pulse.
- respn_data  output  32  mfhi/mflo result, else 0.
REQ-003 The MD-side ports SHALL be:
- md_op  output  4  opcode to MD unit.
- md_rs  output  32  operand A to MD unit.
- md_rt  output  32  operand B to MD unit.
- md_busy  input  1  MD unit busy.
- md_out  input  32  MD read data, combinational from md_op.
REQ-004 Opcodes SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 bds, 10-15 illegal.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-006 In IDLE with md_busy=0, reqn_ready SHALL equal reqn_valid AND grant(n); ready SHALL be 0 in every other state.
REQ-007 Grant SHALL be round-robin:
- If only one requester is valid, it is granted.
- If both are valid, the requester not equal to last_grant is granted.
- last_grant updates on each accept.
REQ-008 On accept (valid AND ready), the block SHALL capture op, rs, rt and owner, and go IDLE->ISSUE.
REQ-009 In ISSUE (exactly one cycle), md_op/md_rs/md_rt SHALL drive the captured values. In all other states md_op SHALL be 0 and md_rs/md_rt SHALL be 0.
REQ-010 From ISSUE with op in 1..4 or 9, the FSM SHALL go to WAIT; for any other op it SHALL go to IDLE.
REQ-011 In WAIT, the FSM SHALL stay while md_busy=1 and go to IDLE on the first cycle md_busy=0.
REQ-012 Completion is ISSUE with a non-start op, or WAIT with md_busy=0. respn_valid for the owner SHALL pulse high in the cycle after completion.
REQ-013 respn_data SHALL be registered: md_out sampled in ISSUE for ops 5/6, otherwise 0. It SHALL hold its value until the next response to the same requester.
REQ-014 Latency from accept edge to resp_valid:
- mfhi/mflo/mthi/mtlo/illegal: 2 cycles.
- mult/multu: 7 cycles (busy 5).
- div/divu/bds: 12 cycles (busy 10).
REQ-015 Illegal ops SHALL still pass through ISSUE with md_op=0 and return a response with data 0.
REQ-016 IDLE SHALL not grant while md_busy=1; no issue SHALL ever overlap MD busy.
REQ-017 A new accept MAY occur in the same cycle resp_valid pulses (back-to-back, 1 idle cycle between ISSUEs minimum).
REQ-018 Requests deasserted before accept SHALL be dropped silently; no request buffering beyond the one captured op.

Reset
REQ-019 On reset, the block SHALL set: state=IDLE, last_grant=1 (so req0 wins the first tie), all ready/resp_valid=0, resp_data=0, md_op/md_rs/md_rt=0, captured registers=0.
REQ-020 Reset mid-ISSUE or mid-WAIT SHALL abort the operation with no response. The MD unit shares the same reset.

Structure
REQ-021 Package md_pkg SHALL hold the opcode constants, the is_start(op) rule (1..4, 9) and the FSM state enum.
REQ-022 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant (inputs valid[1:0], last_grant; output grant one-hot).
REQ-023 Target size: 150-250 lines of RTL.

Verification
REQ-024 req0 mult rs=3, rt=-2 alone -> ready T0, md_op=1 at T1, resp0_valid at T7; a following mflo returns 0xFFFFFFFA, mfhi returns 0xFFFFFFFF.
REQ-025 req0 and req1 both valid from reset -> req0 granted first, then req1; alternation continues under persistent contention.
REQ-026 req1 mthi rs=0x1234 then mfhi -> each resp 2 cycles after accept; mfhi data 0x1234; no WAIT entered.
REQ-027 divu rs=7, rt=2 followed by req0 mfhi held valid throughout -> no ready during WAIT; mfhi data 1; resp at 12 cycles for the divu.
REQ-028 Reset asserted 3 cycles into a div -> state IDLE, no resp pulse, next request serviced normally.
REQ-029 Illegal op 12 -> md_op stays 0, resp_valid 2 cycles after accept, data 0.

Source files
------------

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide request arbiter:
//   - MD opcode constants (0..9 legal, 10..15 illegal)
//   - opcode classification helpers (start / read / legal)
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_BDS   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_e;

  // Ops that start a multi-cycle MD operation and therefore need WAIT.
  function automatic logic is_start(input logic [3:0] op);
    return ((op >= OP_MULT) && (op <= OP_DIVU)) || (op == OP_BDS);
  endfunction

  // Ops whose result is read back from the MD unit during ISSUE.
  function automatic logic is_read(input logic [3:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  // Opcodes the MD unit understands; anything above BDS is illegal.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_BDS);
  endfunction

endpackage

// File: rtl/md_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant.
//   valid[1:0]  : per-requester request pending
//   last_grant  : index of the requester granted most recently
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
// On a tie the requester that was NOT granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Grant selection: single requester wins outright, ties alternate
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (last_grant) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/md_arbiter.sv
// -----------------------------------------------------------------------------
// md_arbiter
// Shares one multiply/divide unit between two requesters.
//   clk, reset                      : clock, synchronous active-high reset
//   reqN_valid/op/rs/rt, reqN_ready : request handshake (ready is combinational)
//   respN_valid, respN_data         : one-cycle completion pulse, held read data
//   md_op/md_rs/md_rt               : registered command to the MD unit
//   md_busy, md_out                 : MD unit status and combinational read data
// One request is captured at a time; it is presented to the MD unit for a
// single ISSUE cycle, then long ops wait for md_busy to drop.
// -----------------------------------------------------------------------------
module md_arbiter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_rs,
  input  logic [31:0] req0_rt,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_rs,
  input  logic [31:0] req1_rt,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  output logic [3:0]  md_op,
  output logic [31:0] md_rs,
  output logic [31:0] md_rt,
  input  logic        md_busy,
  input  logic [31:0] md_out
);

  md_state_e   state_r, state_s;
  logic [3:0]  op_r;
  logic [31:0] rs_r, rt_r;
  logic        owner_r;
  logic        last_grant_r;

  logic [1:0]  valid_s, grant_s, ready_s;
  logic        can_grant_s, accept_s, done_s;
  logic        sel_s;
  logic [3:0]  sel_op_s;
  logic [31:0] sel_rs_s, sel_rt_s, resp_data_s;

  logic [3:0]  md_op_r;
  logic [31:0] md_rs_r, md_rt_r;
  logic [1:0]  resp_valid_r;
  logic [31:0] resp0_data_r, resp1_data_r;

  assign valid_s = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .valid      (valid_s),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // Grants are only offered while idle with the MD unit quiet, never in reset
  always_comb begin
    can_grant_s = 1'b0;
    if ((state_r == ST_IDLE) && !md_busy && !reset) begin
      can_grant_s = 1'b1;
    end else begin
      can_grant_s = 1'b0;
    end
  end

  assign ready_s    = grant_s & {2{can_grant_s}};
  assign accept_s   = |(ready_s & valid_s);
  assign req0_ready = ready_s[0];
  assign req1_ready = ready_s[1];

  // Payload of the granted requester
  always_comb begin
    sel_s    = grant_s[1];
    sel_op_s = req0_op;
    sel_rs_s = req0_rs;
    sel_rt_s = req0_rt;
    if (grant_s[1]) begin
      sel_op_s = req1_op;
      sel_rs_s = req1_rs;
      sel_rt_s = req1_rt;
    end else begin
      sel_op_s = req0_op;
      sel_rs_s = req0_rs;
      sel_rt_s = req0_rt;
    end
  end

  // Completion: short ops finish in ISSUE, long ops when busy drops in WAIT
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      ST_ISSUE: done_s = !is_start(op_r);
      ST_WAIT:  done_s = !md_busy;
      default:  done_s = 1'b0;
    endcase
  end

  // Response data: only mfhi/mflo return MD read data, sampled in ISSUE
  always_comb begin
    resp_data_s = 32'd0;
    if ((state_r == ST_ISSUE) && is_read(op_r)) begin
      resp_data_s = md_out;
    end else begin
      resp_data_s = 32'd0;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (is_start(op_r)) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (md_busy) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and capture of the accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 4'd0;
      rs_r         <= 32'd0;
      rt_r         <= 32'd0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r         <= sel_op_s;
        rs_r         <= sel_rs_s;
        rt_r         <= sel_rt_s;
        owner_r      <= sel_s;
        last_grant_r <= sel_s;
      end
    end
  end

  // MD command registers: loaded on accept so they are live exactly in ISSUE;
  // illegal opcodes are presented as OP_NONE so the MD unit ignores them
  always_ff @(posedge clk) begin
    if (reset) begin
      md_op_r <= OP_NONE;
      md_rs_r <= 32'd0;
      md_rt_r <= 32'd0;
    end else if (accept_s) begin
      md_op_r <= is_legal(sel_op_s) ? sel_op_s : OP_NONE;
      md_rs_r <= sel_rs_s;
      md_rt_r <= sel_rt_s;
    end else begin
      md_op_r <= OP_NONE;
      md_rs_r <= 32'd0;
      md_rt_r <= 32'd0;
    end
  end

  // Response pulse to the owner one cycle after completion; data held until
  // that requester's next response
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_r <= 2'b00;
      resp0_data_r <= 32'd0;
      resp1_data_r <= 32'd0;
    end else begin
      resp_valid_r <= {done_s & owner_r, done_s & !owner_r};
      if (done_s && owner_r) begin
        resp1_data_r <= resp_data_s;
      end
      if (done_s && !owner_r) begin
        resp0_data_r <= resp_data_s;
      end
    end
  end

  assign md_op       = md_op_r;
  assign md_rs       = md_rs_r;
  assign md_rt       = md_rt_r;
  assign resp0_valid = resp_valid_r[0];
  assign resp1_valid = resp_valid_r[1];
  assign resp0_data  = resp0_data_r;
  assign resp1_data  = resp1_data_r;

endmodule

// File: tb/tb_md_arbiter.sv
// -----------------------------------------------------------------------------
// tb_md_arbiter
// Drives md_arbiter from two request queues, emulates the MD unit (HI/LO
// registers, busy 5 cycles for mult, 10 for div/bds, counted from the ISSUE
// cycle), and checks every cycle against a transaction-level model: the next
// free cycle, the expected grant, the ISSUE cycle and the response cycle/data
// are all derived from the accept cycle plus the opcode latency.
// -----------------------------------------------------------------------------
module tb_md_arbiter;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
  } req_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic [3:0]  md_op;
  logic [31:0] md_rs, md_rt, md_out;
  logic        md_busy;

  int errors = 0;
  int checks = 0;

  md_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_rs(req0_rs), .req0_rt(req0_rt),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_rs(req1_rs), .req1_rt(req1_rt),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .md_op(md_op), .md_rs(md_rs), .md_rt(md_rt), .md_busy(md_busy), .md_out(md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // New {hi,lo} after an MD operation (MIPS semantics: hi=remainder, lo=quotient)
  function automatic logic [63:0] md_math(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic signed [31:0] a, b;
    logic [63:0] ea, eb, r;
    a = rs;
    b = rt;
    r = {hi, lo};
    case (op)
      4'd1: begin ea = {{32{rs[31]}}, rs}; eb = {{32{rt[31]}}, rt}; r = ea * eb; end
      4'd2: begin ea = {32'd0, rs}; eb = {32'd0, rt}; r = ea * eb; end
      4'd3: r = {32'(a % b), 32'(a / b)};
      4'd4: r = {rs % rt, rs / rt};
      4'd7: r = {rs, lo};
      4'd8: r = {hi, rs};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // ---------------- MD unit emulation ----------------
  logic [31:0] env_hi, env_lo;
  int          env_cnt;

  assign md_busy = ((md_op >= 4'd1 && md_op <= 4'd4) || md_op == 4'd9) || (env_cnt != 0);
  assign md_out  = (md_op == 4'd5) ? env_hi : (md_op == 4'd6) ? env_lo : 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      env_cnt <= 0;
      env_hi  <= 32'd0;
      env_lo  <= 32'd0;
    end else begin
      if (md_op == 4'd1 || md_op == 4'd2) env_cnt <= 4;
      else if (md_op == 4'd3 || md_op == 4'd4 || md_op == 4'd9) env_cnt <= 9;
      else if (env_cnt != 0) env_cnt <= env_cnt - 1;
      {env_hi, env_lo} <= md_math(md_op, md_rs, md_rt, env_hi, env_lo);
    end
  end

  // ---------------- transaction-level reference model ----------------
  req_t        rq [2][$];
  int          cyc, free_cyc, issue_cyc, pend_cyc, pend_owner;
  bit          pend, issue_v, last_g;
  req_t        issue_req;
  logic [31:0] pend_data, m_hi, m_lo;
  logic [31:0] exp_data [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; free_cyc = 0; pend = 1'b0; issue_v = 1'b0; last_g = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0; exp_data[0] = 32'd0; exp_data[1] = 32'd0;
    rq[0].delete(); rq[1].delete();
  endtask

  task automatic push(input int n, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt);
    req_t r;
    r.op = op; r.rs = rs; r.rt = rt;
    rq[n].push_back(r);
  endtask

  // One clock: drive at posedge+1, check at posedge+3, predict, advance
  task automatic step();
    int   g, lat;
    bit   v0, v1, resp_now;
    req_t r;
    v0 = rq[0].size() > 0;
    v1 = rq[1].size() > 0;
    req0_valid = v0; req1_valid = v1;
    if (v0) begin r = rq[0][0]; req0_op = r.op; req0_rs = r.rs; req0_rt = r.rt; end
    else begin req0_op = 4'($urandom); req0_rs = $urandom; req0_rt = $urandom; end
    if (v1) begin r = rq[1][0]; req1_op = r.op; req1_rs = r.rs; req1_rt = r.rt; end
    else begin req1_op = 4'($urandom); req1_rs = $urandom; req1_rt = $urandom; end
    #2;
    g = -1;
    if (cyc >= free_cyc) begin
      if (v0 && v1) g = last_g ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    resp_now = pend && (cyc == pend_cyc);
    if (resp_now) exp_data[pend_owner] = pend_data;
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    chk("resp0_valid", 32'(resp0_valid), 32'(resp_now && pend_owner == 0));
    chk("resp1_valid", 32'(resp1_valid), 32'(resp_now && pend_owner == 1));
    chk("resp0_data", resp0_data, exp_data[0]);
    chk("resp1_data", resp1_data, exp_data[1]);
    if (issue_v && cyc == issue_cyc) begin
      chk("md_op", 32'(md_op), (issue_req.op <= 4'd9) ? 32'(issue_req.op) : 32'd0);
      chk("md_rs", md_rs, issue_req.rs);
      chk("md_rt", md_rt, issue_req.rt);
    end else begin
      chk("md_op_idle", 32'(md_op), 32'd0);
      chk("md_rs_idle", md_rs, 32'd0);
      chk("md_rt_idle", md_rt, 32'd0);
    end
    if (resp_now) pend = 1'b0;
    if (g >= 0) begin
      r = rq[g].pop_front();
      if (r.op == 4'd1 || r.op == 4'd2) lat = 7;
      else if (r.op == 4'd3 || r.op == 4'd4 || r.op == 4'd9) lat = 12;
      else lat = 2;
      pend = 1'b1; pend_cyc = cyc + lat; pend_owner = g;
      pend_data = (r.op == 4'd5) ? m_hi : (r.op == 4'd6) ? m_lo : 32'd0;
      {m_hi, m_lo} = md_math(r.op, r.rs, r.rt, m_hi, m_lo);
      issue_v = 1'b1; issue_cyc = cyc + 1; issue_req = r;
      free_cyc = cyc + lat;
      last_g = (g == 1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until all queued work has been responded to, within a cycle budget
  task automatic run_idle(input int max);
    int k;
    k = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0 || pend) && k < max) begin
      step();
      k++;
    end
    checks++;
    assert (k < max) else begin
      errors++;
      $error("FAIL timeout: observed=%0d cycles required<%0d", k, max);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req0_rs = 32'd0; req0_rt = 32'd0;
    req1_op = 4'd0; req1_rs = 32'd0; req1_rt = 32'd0;
    model_reset();
    @(negedge clk);
    do_reset(2);
    run(2);                                   // reset state, no requests

    // mult 3 * -2, then read lo and hi
    push(0, 4'd1, 32'd3, 32'hFFFF_FFFE);
    run_idle(40);
    push(0, 4'd6, 32'd0, 32'd0);
    run_idle(40);
    chk("mflo_value", resp0_data, 32'hFFFF_FFFA);
    push(0, 4'd5, 32'd0, 32'd0);
    run_idle(40);
    chk("mfhi_value", resp0_data, 32'hFFFF_FFFF);

    // contention straight after reset: req0 first, then alternation
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      push(0, 4'd7, 32'(i), 32'd0);
      push(1, 4'd8, 32'(i + 16), 32'd0);
    end
    run_idle(100);

    // mthi then mfhi on req1
    push(1, 4'd7, 32'h0000_1234, 32'd0);
    push(1, 4'd5, 32'd0, 32'd0);
    run_idle(40);
    chk("mthi_mfhi", resp1_data, 32'h0000_1234);

    // divu with an mfhi held pending throughout the wait
    push(1, 4'd4, 32'd7, 32'd2);
    step();
    push(0, 4'd5, 32'd0, 32'd0);
    run_idle(60);
    chk("divu_rem", resp0_data, 32'd1);

    // reset three cycles into a div, then normal service
    push(0, 4'd3, 32'd100, 32'd7);
    run(4);
    do_reset(1);
    run(3);
    push(1, 4'd8, 32'd55, 32'd0);
    push(1, 4'd6, 32'd0, 32'd0);
    run_idle(40);
    chk("after_reset", resp1_data, 32'd55);

    // illegal op returns zero data after a non-zero read
    push(0, 4'd7, 32'h0000_ABCD, 32'd0);
    push(0, 4'd5, 32'd0, 32'd0);
    run_idle(40);
    chk("pre_illegal", resp0_data, 32'h0000_ABCD);
    push(0, 4'd12, 32'd5, 32'd6);
    run_idle(40);
    chk("illegal_data", resp0_data, 32'd0);

    // randomized traffic with occasional withdrawn requests
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (rq[n].size() > 0 && ($urandom % 16) == 0) void'(rq[n].pop_front());
        if (rq[n].size() < 2 && ($urandom % 4) == 0) begin
          logic [3:0]  op;
          logic [31:0] rt;
          op = 4'($urandom_range(0, 15));
          rt = $urandom;
          if (op == 4'd3 || op == 4'd4) rt = 32'($urandom_range(1, 1000));
          push(n, op, $urandom, rt);
        end
      end
      step();
    end
    run_idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
